// File: rtl/mc_tq_sched_pkg.sv
// Shared definitions for the MC-to-TQ per-LCU sequencer: component codes,
// partition field widths and the sequencer state encoding.
package mc_tq_sched_pkg;

    localparam logic [1:0] TYPE_Y = 2'd0;
    localparam logic [1:0] TYPE_U = 2'd1;
    localparam logic [1:0] TYPE_V = 2'd2;

    localparam logic PART_SPLIT = 1'b1;

    // Packed partition layout: 16x16 flags, then 32x32, then 64x64
    localparam int P16_W  = 32;
    localparam int P32_W  = 8;
    localparam int P64_W  = 2;
    localparam int PART_W = P16_W + P32_W + P64_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Component code to its bit in the {V,U,Y} mask
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            TYPE_Y:  sel_onehot = 3'b001;
            TYPE_U:  sel_onehot = 3'b010;
            TYPE_V:  sel_onehot = 3'b100;
            default: sel_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mc_tq_sched_pick.sv
// Next-pending component selector: first set bit of the {V,U,Y} mask in
// Y, U, V order, with a flag when nothing is left to run.
module mc_tq_sched_pick
    import mc_tq_sched_pkg::*;
(
    input  logic [2:0] mask,
    output logic [1:0] sel,
    output logic       none
);

    always_comb begin
        sel  = TYPE_Y;
        none = 1'b0;
        if (mask[0])      sel = TYPE_Y;
        else if (mask[1]) sel = TYPE_U;
        else if (mask[2]) sel = TYPE_V;
        else              none = 1'b1;
    end

endmodule

// File: rtl/mc_tq_sched.sv
// Per-LCU sequencer running the MC-to-TQ engine for Y, U, V in order.
// Optional busy-cycle counter enabled by MC_TQ_SCHED_CYC_CNT_EN.
module mc_tq_sched
    import mc_tq_sched_pkg::*;
#(
    parameter int PART_W = 42,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [PART_W-1:0] partition_i,
    input  logic [2:0]        skip_i,
    input  logic              tq_done_i,
    output logic              done_o,
    output logic              busy_o,
    output logic              tq_start_o,
    output logic [1:0]        tq_sel_o,
    output logic [PART_W-1:0] tq_partition_o,
    output logic              err_o
`ifdef MC_TQ_SCHED_CYC_CNT_EN
    ,
    output logic [CNT_W-1:0]  cyc_cnt_o
`endif
);

    state_t     state;
    logic [2:0] pending;
    logic [2:0] skip_q;
    logic [2:0] pick_mask;
    logic [1:0] pick_sel;
    logic       pick_none;

    // In IDLE choose from the incoming mask; in WAIT from what remains
    // once the component that just finished is retired.
    assign pick_mask = (state == S_IDLE) ? ~skip_i
                     : (pending & ~skip_q & ~sel_onehot(tq_sel_o));

    mc_tq_sched_pick u_pick (
        .mask (pick_mask),
        .sel  (pick_sel),
        .none (pick_none)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            pending        <= 3'b000;
            skip_q         <= 3'b000;
            done_o         <= 1'b0;
            busy_o         <= 1'b0;
            tq_start_o     <= 1'b0;
            tq_sel_o       <= TYPE_Y;
            tq_partition_o <= '0;
            err_o          <= 1'b0;
        end else begin
            tq_start_o <= 1'b0;
            done_o     <= 1'b0;
            if (tq_done_i && state != S_WAIT) err_o <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        tq_partition_o <= partition_i;
                        skip_q         <= skip_i;
                        pending        <= ~skip_i;
                        busy_o         <= 1'b1;
                        tq_sel_o       <= pick_sel;
                        if (pick_none) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state      <= S_LAUNCH;
                            tq_start_o <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: state <= S_WAIT;
                S_WAIT: begin
                    if (tq_done_i) begin
                        pending <= pick_mask;
                        if (pick_none) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            tq_sel_o   <= pick_sel;
                            state      <= S_LAUNCH;
                            tq_start_o <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MC_TQ_SCHED_CYC_CNT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // Published value includes the done cycle itself
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            cyc_cnt_o <= '0;
        end else begin
            if (state == S_IDLE && start_i) cnt <= '0;
            else if (busy_o)                cnt <= cnt_inc;
            if (state == S_DONE) cyc_cnt_o <= cnt_inc;
        end
    end
`endif

endmodule

// File: tb/tb_mc_tq_sched.sv
// Directed bench for mc_tq_sched; checks the cycle counter too when built
// with MC_TQ_SCHED_CYC_CNT_EN.
module tb_mc_tq_sched;
    localparam int PART_W = 42;
    localparam int CNT_W  = 16;

    localparam logic [PART_W-1:0] PART_A = 42'h2AB_CDEF_1234;
    localparam logic [PART_W-1:0] PART_B = 42'h155_5555_5555;
    localparam logic [PART_W-1:0] PART_C = 42'h0F0_0F0F_A5A5;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start_i = 1'b0;
    logic [PART_W-1:0] partition_i = '0;
    logic [2:0]        skip_i = 3'b000;
    logic              tq_done_i = 1'b0;
    logic              done_o, busy_o, tq_start_o, err_o;
    logic [1:0]        tq_sel_o;
    logic [PART_W-1:0] tq_partition_o;
`ifdef MC_TQ_SCHED_CYC_CNT_EN
    logic [CNT_W-1:0]  cyc_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int start_seen = 0;
    int done_seen = 0;
    int s0, d0;

    mc_tq_sched #(.PART_W(PART_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start_i        (start_i),
        .partition_i    (partition_i),
        .skip_i         (skip_i),
        .tq_done_i      (tq_done_i),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .tq_start_o     (tq_start_o),
        .tq_sel_o       (tq_sel_o),
        .tq_partition_o (tq_partition_o),
        .err_o          (err_o)
`ifdef MC_TQ_SCHED_CYC_CNT_EN
        ,
        .cyc_cnt_o      (cyc_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tq_start_o) start_seen++;
        if (done_o)     done_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the cycle right after the accepting edge
    task automatic start_lcu(input logic [PART_W-1:0] p, input logic [2:0] s);
        partition_i = p;
        skip_i      = s;
        start_i     = 1'b1;
        step();
        start_i     = 1'b0;
    endtask

    // From a LAUNCH cycle: n cycles of engine work, then one done pulse;
    // leaves the bench in the cycle after the done edge.
    task automatic finish_pass(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0) chk("start_one_cycle", tq_start_o, 1'b0);
        end
        tq_done_i = 1'b1;
        step();
        tq_done_i = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_start", tq_start_o, 1'b0);
        chk("rst_sel", tq_sel_o, 2'd0);
        chk("rst_part", tq_partition_o, '0);
        chk("rst_err", err_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Full Y, U, V run with 20-cycle passes
        s0 = start_seen; d0 = done_seen;
        start_lcu(PART_A, 3'b000);
        chk("yuv_start_y", tq_start_o, 1'b1);
        chk("yuv_sel_y", tq_sel_o, 2'd0);
        chk("yuv_busy", busy_o, 1'b1);
        chk("yuv_part", tq_partition_o, PART_A);
        finish_pass(20);
        chk("yuv_start_u", tq_start_o, 1'b1);
        chk("yuv_sel_u", tq_sel_o, 2'd1);
        chk("yuv_busy_u", busy_o, 1'b1);
        finish_pass(20);
        chk("yuv_start_v", tq_start_o, 1'b1);
        chk("yuv_sel_v", tq_sel_o, 2'd2);
        finish_pass(20);
        chk("yuv_done", done_o, 1'b1);
        chk("yuv_busy_done", busy_o, 1'b1);
        chk("yuv_nostart", tq_start_o, 1'b0);
        step();
`ifdef MC_TQ_SCHED_CYC_CNT_EN
        chk("yuv_cyc", cyc_cnt_o, 16'd64);
`endif
        chk("yuv_done_pulse", done_o, 1'b0);
        chk("yuv_busy_drop", busy_o, 1'b0);
        chk("yuv_n_start", start_seen - s0, 3);
        chk("yuv_n_done", done_seen - d0, 1);

        // Y only
        s0 = start_seen;
        start_lcu(PART_B, 3'b110);
        chk("y_start", tq_start_o, 1'b1);
        chk("y_sel", tq_sel_o, 2'd0);
        finish_pass(5);
        chk("y_done", done_o, 1'b1);
        chk("y_nostart", tq_start_o, 1'b0);
        step();
        chk("y_idle", busy_o, 1'b0);
        chk("y_n_start", start_seen - s0, 1);

        // All skipped: done at T+1, engine never started
        s0 = start_seen;
        start_lcu(PART_C, 3'b111);
        chk("all_done", done_o, 1'b1);
        chk("all_busy", busy_o, 1'b1);
        chk("all_nostart", tq_start_o, 1'b0);
        step();
        chk("all_idle", busy_o, 1'b0);
        chk("all_n_start", start_seen - s0, 0);

        // U only; partition change and extra start while waiting
        s0 = start_seen; d0 = done_seen;
        start_lcu(PART_B, 3'b101);
        chk("hold_sel_u", tq_sel_o, 2'd1);
        step();
        partition_i = PART_A;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("hold_part", tq_partition_o, PART_B);
        chk("hold_sel", tq_sel_o, 2'd1);
        finish_pass(3);
        chk("hold_done", done_o, 1'b1);
        step();
        step();
        chk("hold_n_done", done_seen - d0, 1);
        chk("hold_n_start", start_seen - s0, 1);
        chk("hold_part_idle", tq_partition_o, PART_B);

        // Engine done while idle
        chk("err_clear", err_o, 1'b0);
        tq_done_i = 1'b1;
        step();
        tq_done_i = 1'b0;
        chk("err_set", err_o, 1'b1);
        chk("err_idle_busy", busy_o, 1'b0);
        chk("err_idle_start", tq_start_o, 1'b0);
        repeat (3) step();
        chk("err_sticky", err_o, 1'b1);

        // Asynchronous reset during the second wait
        d0 = done_seen;
        start_lcu(PART_A, 3'b000);
        finish_pass(4);
        chk("rst_mid_sel_u", tq_sel_o, 2'd1);
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_busy", busy_o, 1'b0);
        chk("rst_mid_sel", tq_sel_o, 2'd0);
        chk("rst_mid_part", tq_partition_o, '0);
        chk("rst_mid_err", err_o, 1'b0);
        chk("rst_mid_start", tq_start_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        step();
        chk("rst_mid_no_done", done_seen - d0, 0);

        // Fresh run after reset with 10-cycle passes
        s0 = start_seen;
        start_lcu(PART_C, 3'b000);
        chk("fresh_part", tq_partition_o, PART_C);
        finish_pass(10);
        chk("fresh_sel_u", tq_sel_o, 2'd1);
        finish_pass(10);
        chk("fresh_sel_v", tq_sel_o, 2'd2);
        finish_pass(10);
        chk("fresh_done", done_o, 1'b1);
        step();
`ifdef MC_TQ_SCHED_CYC_CNT_EN
        chk("fresh_cyc", cyc_cnt_o, 16'd34);
`endif
        chk("fresh_n_start", start_seen - s0, 3);

        // Engine done coinciding with the launch pulse is spurious
        d0 = done_seen;
        start_lcu(PART_A, 3'b110);
        chk("spur_err0", err_o, 1'b0);
        tq_done_i = 1'b1;
        step();
        tq_done_i = 1'b0;
        chk("spur_err", err_o, 1'b1);
        chk("spur_no_done", done_o, 1'b0);
        chk("spur_busy", busy_o, 1'b1);
        finish_pass(2);
        chk("spur_done", done_o, 1'b1);
        step();
        chk("spur_n_done", done_seen - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
